// File: rtl/wr_address_decoder_512_if.sv
// wr_address_decoder_512_if: AXI4 write-channel bundle (aw/w/b) between the line writer and DDR
interface wr_address_decoder_512_if;
   logic         aw_valid;
   logic         aw_ready;
   logic [31:0]  aw_addr;
   logic [7:0]   aw_len;
   logic         w_valid;
   logic         w_ready;
   logic         w_last;
   logic [511:0] w_data;
   logic [63:0]  w_strb;
   logic         b_valid;
   logic         b_ready;
   logic [1:0]   b_resp;
   modport master (
      output aw_valid, aw_addr, aw_len, w_valid, w_last, w_data, w_strb, b_ready,
      input  aw_ready, w_ready, b_valid, b_resp
   );
   modport slave (
      input  aw_valid, aw_addr, aw_len, w_valid, w_last, w_data, w_strb, b_ready,
      output aw_ready, w_ready, b_valid, b_resp
   );
endinterface

// File: rtl/wr_address_decoder_512.sv
// wr_address_decoder_512: packs 4-pixel beats into 512-bit words and writes each line to DDR as AXI4 INCR bursts
// Optional WR_BRESP_CHK_EN: counts non-OKAY write responses on out_err_cnt (tied 0 when undefined).
module wr_address_decoder_512 #(
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 32
) (
   input  logic        axi_clk,
   input  logic        rstn,
   input  logic [11:0] x_win,
   input  logic [11:0] x_start,
   input  logic [11:0] y_win,
   input  logic [11:0] y_start,
   input  logic        in_de,
   input  logic        in_valid,
   input  logic        in_vsync,
   input  logic [31:0] in_pix,
   output logic        out_in_ready,
   output logic [2:0]  out_frame_cnt,
   output logic        out_ovf,
   output logic [7:0]  out_err_cnt,
   wr_address_decoder_512_if.master axi
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP} state_t;
   state_t state, state_nx;
   logic [511:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic [511:0] pk_word, pk_ins, push_data;
   logic [3:0] pk_idx;
   logic push_v, de_q, vs_q, flush_pend, frame_pend;
   logic [11:0] y_cnt;
   logic [5:0] x_word;
   logic [6:0] words_left, words_line, wl, b_sz, blen, beat;
   logic beat_ok, fill_done, pad_done, flush, go, pop, last_beat, b_done, unused_bits;
   always_comb begin
      pk_ins = pk_word;
      pk_ins[{pk_idx, 5'd0} +: 32] = in_pix;
   end
   assign beat_ok    = in_valid & in_de & out_in_ready;
   assign fill_done  = beat_ok && pk_idx == 4'd15;
   assign pad_done   = de_q && !in_de && pk_idx != 4'd0;
   assign words_line = 7'((13'(x_win) + 13'd63) >> 6);
   assign wl         = words_left == 7'd0 ? words_line : words_left;
   assign b_sz       = wl > 7'(BURST_LEN) ? 7'(BURST_LEN) : wl;
   // blanking clears the line state only between bursts; a burst in flight always finishes
   assign flush      = state == IDLE && (!in_vsync || flush_pend);
   assign go         = state == IDLE && !flush && !frame_pend && b_sz != 7'd0 && 7'(count) >= b_sz;
   assign pop        = state == WR_DATA && count != '0 && axi.w_ready;
   assign last_beat  = beat == blen - 7'd1;
   assign b_done     = state == WR_RESP && axi.b_valid;
   assign axi.w_data = mem[rd_ptr];
   assign axi.w_strb = '1;
   always_comb begin
      axi.aw_valid = state == WR_ADDR;
      axi.w_valid  = state == WR_DATA && count != '0;
      axi.w_last   = state == WR_DATA && count != '0 && last_beat;
      axi.b_ready  = state == WR_RESP;
      state_nx     = go ? WR_ADDR :
                     (state == WR_ADDR && axi.aw_ready) ? WR_DATA :
                     (pop && last_beat) ? WR_RESP :
                     b_done ? IDLE : state;
   end
   always_ff @(posedge axi_clk or negedge rstn)
      if (!rstn) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge axi_clk)
      if (push_v && !flush) mem[wr_ptr] <= push_data;
   always_ff @(posedge axi_clk or negedge rstn) begin
      if (!rstn) begin
         de_q          <= 1'b0;
         vs_q          <= 1'b0;
         out_in_ready  <= 1'b0;
         out_ovf       <= 1'b0;
         out_frame_cnt <= '0;
         flush_pend    <= 1'b0;
         frame_pend    <= 1'b0;
         pk_word       <= '0;
         pk_idx        <= '0;
         push_v        <= 1'b0;
         push_data     <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         y_cnt         <= '0;
         x_word        <= '0;
         words_left    <= '0;
         blen          <= '0;
         beat          <= '0;
         axi.aw_addr   <= '0;
         axi.aw_len    <= '0;
      end else begin
         de_q         <= in_de;
         vs_q         <= in_vsync;
         out_in_ready <= count <= (AW+1)'(FIFO_DEPTH - 2);
         out_ovf      <= in_vsync && (out_ovf || (in_valid && !out_in_ready));
         flush_pend   <= state != IDLE && (flush_pend || !in_vsync);
         frame_pend   <= (vs_q && !in_vsync) || (frame_pend && state != IDLE);
         if (frame_pend && state == IDLE) out_frame_cnt <= out_frame_cnt + 3'd1;
         if (flush) begin
            pk_word    <= '0;
            pk_idx     <= '0;
            push_v     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            y_cnt      <= '0;
            x_word     <= '0;
            words_left <= '0;
         end else begin
            push_v  <= fill_done | pad_done;
            if (fill_done | pad_done) push_data <= fill_done ? pk_ins : pk_word;
            pk_word <= (fill_done || pad_done) ? '0 : beat_ok ? pk_ins : pk_word;
            pk_idx  <= pad_done ? 4'd0 : beat_ok ? pk_idx + 4'd1 : pk_idx;
            if (push_v) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count   <= count + (AW+1)'(push_v) - (AW+1)'(pop);
         end
         if (go) begin
            words_left  <= wl;
            blen        <= b_sz;
            beat        <= '0;
            axi.aw_addr <= {5'b0, out_frame_cnt, y_cnt + y_start, x_word + x_start[11:6], 6'b0};
            axi.aw_len  <= 8'(b_sz - 7'd1);
         end
         if (pop) beat <= beat + 7'd1;
         if (b_done) begin
            words_left <= words_left - blen;
            x_word     <= words_left == blen ? 6'd0 : x_word + 6'(blen);
            if (words_left == blen) y_cnt <= y_cnt == y_win - 12'd1 ? '0 : y_cnt + 12'd1;
         end
      end
   end
`ifdef WR_BRESP_CHK_EN
   always_ff @(posedge axi_clk or negedge rstn)
      if (!rstn) out_err_cnt <= '0;
      else if (b_done && axi.b_resp != 2'd0 && out_err_cnt != 8'hFF) out_err_cnt <= out_err_cnt + 8'd1;
   assign unused_bits = ^x_start[5:0];
`else
   assign out_err_cnt = '0;
   assign unused_bits = ^{x_start[5:0], axi.b_resp};
`endif
endmodule
